// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: start, LSB-first data, optional parity, stop.
// Bit period comes from a prescale value latched when the byte is accepted.
module uart_tx_ctrl #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned PS_W   = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] P_DATA,
    input  logic              DATA_VALID,
    input  logic              PAR_EN,
    input  logic              PAR_TYP,
    input  logic [PS_W-1:0]   PRESCALE,
    output logic              TX_OUT,
    output logic              BUSY,
    output logic              DONE
);

    localparam int unsigned BW = $clog2(DATA_W + 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    logic [2:0]        state, state_d;
    logic [PS_W-1:0]   cnt, cnt_d;
    logic [PS_W-1:0]   ps_q, ps_d;
    logic [BW-1:0]     idx, idx_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] data_sh;
    logic              par_en_q, par_en_d;
    logic              par_bit_q, par_bit_d;
    logic              tx_d, busy_d, done_d;
    logic              last;

    assign last    = (cnt == ps_q - PS_W'(1));
    assign data_sh = data_q >> 1;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            cnt       <= '0;
            ps_q      <= '0;
            idx       <= '0;
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            TX_OUT    <= 1'b1;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            ps_q      <= ps_d;
            idx       <= idx_d;
            data_q    <= data_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            TX_OUT    <= tx_d;
            BUSY      <= busy_d;
            DONE      <= done_d;
        end
    end

    // Next-state and next-output logic; data_q shifts so bit 0 is always the next data bit.
    always_comb begin
        state_d   = state;
        cnt_d     = last ? '0 : cnt + PS_W'(1);
        ps_d      = ps_q;
        idx_d     = idx;
        data_d    = data_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        tx_d      = 1'b1;
        busy_d    = 1'b1;
        done_d    = 1'b0;

        case (state)
            IDLE: begin
                busy_d = 1'b0;
                cnt_d  = '0;
                if (DATA_VALID) begin
                    state_d   = START;
                    data_d    = P_DATA;
                    par_en_d  = PAR_EN;
                    par_bit_d = PAR_TYP ? ~(^P_DATA) : (^P_DATA);
                    ps_d      = (PRESCALE == '0) ? PS_W'(1) : PRESCALE;
                    tx_d      = 1'b0;
                    busy_d    = 1'b1;
                end
            end
            START: begin
                tx_d = 1'b0;
                if (last) begin
                    state_d = DATA;
                    idx_d   = '0;
                    tx_d    = data_q[0];
                end
            end
            DATA: begin
                tx_d = data_q[0];
                if (last) begin
                    if (idx == BW'(DATA_W - 1)) begin
                        state_d = par_en_q ? PARITY : STOP;
                        tx_d    = par_en_q ? par_bit_q : 1'b1;
                    end else begin
                        idx_d  = idx + BW'(1);
                        data_d = data_sh;
                        tx_d   = data_sh[0];
                    end
                end
            end
            PARITY: begin
                tx_d = par_bit_q;
                if (last) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
            STOP: begin
                if (last) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl: queued frame requests are checked
// bit-by-bit on the serial line when the DUT starts each frame.
module tb_uart_tx_ctrl;

    typedef struct {
        logic [7:0] data;
        logic       pe;
        logic       pt;
        int         ps;
    } frame_t;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] P_DATA;
    logic       DATA_VALID;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [7:0] PRESCALE;
    logic       TX_OUT;
    logic       BUSY;
    logic       DONE;

    int vectors = 0;
    int errors  = 0;
    int done_seen = 0;
    frame_t sb_q[$];

    uart_tx_ctrl #(.DATA_W(8), .PS_W(8)) dut (
        .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .DATA_VALID(DATA_VALID),
        .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .PRESCALE(PRESCALE),
        .TX_OUT(TX_OUT), .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Frame monitor: pops the expected frame when BUSY rises and checks every cycle.
    bit   active = 1'b0;
    bit   pend_done = 1'b0;
    bit   spurious = 1'b0;
    int   cyc, eps, nbits;
    logic exp_bits[0:10];

    always @(negedge CLK) begin
        if (RST) begin
            active    = 1'b0;
            pend_done = 1'b0;
            spurious  = 1'b0;
        end else begin
            if (DONE) done_seen++;
            if (pend_done) begin
                check_eq("done_pulse", 32'(DONE), 32'(1));
                check_eq("done_busy", 32'(BUSY), 32'(0));
                check_eq("done_line", 32'(TX_OUT), 32'(1));
                pend_done = 1'b0;
            end else if (!active && BUSY && !spurious) begin
                if (sb_q.size() == 0) begin
                    check_eq("spurious_frame", 32'(BUSY), 32'(0));
                    spurious = 1'b1;
                end else begin
                    frame_t f;
                    int ones;
                    f = sb_q.pop_front();
                    eps = (f.ps == 0) ? 1 : f.ps;
                    ones = 0;
                    exp_bits[0] = 1'b0;
                    for (int i = 0; i < 8; i++) begin
                        exp_bits[i+1] = f.data[i];
                        ones += int'(f.data[i]);
                    end
                    if (f.pe) begin
                        exp_bits[9]  = ((ones % 2) == 1) ^ f.pt;
                        exp_bits[10] = 1'b1;
                        nbits = 11;
                    end else begin
                        exp_bits[9] = 1'b1;
                        nbits = 10;
                    end
                    active = 1'b1;
                    cyc = 0;
                end
            end else if (!BUSY) begin
                spurious = 1'b0;
            end
            if (active) begin
                check_eq("tx_bit", 32'(TX_OUT), 32'(exp_bits[cyc / eps]));
                check_eq("busy", 32'(BUSY), 32'(1));
                check_eq("done_early", 32'(DONE), 32'(0));
                cyc++;
                if (cyc == eps * nbits) begin
                    active    = 1'b0;
                    pend_done = 1'b1;
                end
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic pe, input logic pt, input logic [7:0] ps);
        @(negedge CLK);
        P_DATA = d; PAR_EN = pe; PAR_TYP = pt; PRESCALE = ps; DATA_VALID = 1'b1;
        sb_q.push_back('{data: d, pe: pe, pt: pt, ps: int'(ps)});
        @(negedge CLK);
        DATA_VALID = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge CLK);
            if (DONE) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check_eq("done_timeout", 32'(DONE), 32'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1; P_DATA = '0; DATA_VALID = 1'b0; PAR_EN = 1'b0; PAR_TYP = 1'b0; PRESCALE = '0;
        repeat (3) @(negedge CLK);
        check_eq("rst_tx", 32'(TX_OUT), 32'(1));
        check_eq("rst_busy", 32'(BUSY), 32'(0));
        check_eq("rst_done", 32'(DONE), 32'(0));
        RST = 1'b0;
        repeat (2) @(negedge CLK);

        send(8'hA5, 1'b1, 1'b0, 8'd4); wait_done(100);
        send(8'h01, 1'b1, 1'b1, 8'd1); wait_done(30);
        send(8'h01, 1'b1, 1'b0, 8'd1); wait_done(30);
        send(8'hFF, 1'b0, 1'b0, 8'd1); wait_done(30);
        send(8'h3C, 1'b0, 1'b0, 8'd0); wait_done(30);

        // Mid-frame input changes must not disturb the frame or start another.
        send(8'h5A, 1'b0, 1'b0, 8'd2);
        repeat (5) @(negedge CLK);
        P_DATA = 8'hFF; PRESCALE = 8'd7; PAR_EN = 1'b1; DATA_VALID = 1'b1;
        @(negedge CLK);
        DATA_VALID = 1'b0;
        wait_done(60);
        repeat (6) @(negedge CLK);

        // Back-to-back with DATA_VALID held high.
        @(negedge CLK);
        P_DATA = 8'h55; PAR_EN = 1'b0; PAR_TYP = 1'b0; PRESCALE = 8'd2; DATA_VALID = 1'b1;
        sb_q.push_back('{data: 8'h55, pe: 1'b0, pt: 1'b0, ps: 2});
        for (int i = 0; i < 10 && !BUSY; i++) @(negedge CLK);
        check_eq("b2b_first_busy", 32'(BUSY), 32'(1));
        P_DATA = 8'hAA;
        sb_q.push_back('{data: 8'hAA, pe: 1'b0, pt: 1'b0, ps: 2});
        wait_done(60);
        check_eq("b2b_gap_line", 32'(TX_OUT), 32'(1));
        @(negedge CLK);
        check_eq("b2b_start", 32'({BUSY, TX_OUT}), 32'(2'b10));
        DATA_VALID = 1'b0;
        wait_done(60);
        repeat (3) @(negedge CLK);

        // Reset during data bit 3 aborts the frame at once.
        send(8'hC3, 1'b1, 1'b0, 8'd3);
        repeat (13) @(negedge CLK);
        #1 RST = 1'b1;
        #1;
        check_eq("abort_tx", 32'(TX_OUT), 32'(1));
        check_eq("abort_busy", 32'(BUSY), 32'(0));
        check_eq("abort_done", 32'(DONE), 32'(0));
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        check_eq("post_rst_idle", 32'({BUSY, DONE, TX_OUT}), 32'(3'b001));

        send(8'h81, 1'b1, 1'b1, 8'd2); wait_done(60);
        repeat (4) @(negedge CLK);

        check_eq("done_count", 32'(done_seen), 32'(9));
        check_eq("sb_empty", 32'(sb_q.size()), 32'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
Frame sequencer for the UART transmit path. It accepts a parallel byte with a valid strobe and runs the frame sequence start -> data bits LSB-first -> optional parity -> stop. Bit timing comes from an internal prescale counter. Parity is computed on the latched byte at accept time, and the block drives the serial line, the busy flag and a frame-done pulse.

Parameters:
DATA_W, 8, data bits per frame (1..16)
PS_W, 8, width of PRESCALE input (clocks-per-bit counter width)

Ports:
CLK  in  1  system clock, all state on rising edge
RST  in  1  asynchronous, active-high reset
P_DATA  in  DATA_W  parallel data to send
DATA_VALID  in  1  request strobe; accepted only when BUSY=0
PAR_EN  in  1  1 = insert parity bit after data
PAR_TYP  in  1  0 = even parity, 1 = odd parity
PRESCALE  in  PS_W  clocks per bit; 0 treated as 1
TX_OUT  out  1  serial line, idle high
BUSY  out  1  frame in progress
DONE  out  1  one-cycle pulse at frame completion

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high.
- Reset values: TX_OUT=1, BUSY=0, DONE=0, state=IDLE, counters=0. Asserting RST mid-frame aborts the frame immediately, with TX_OUT high asynchronously. No DONE is produced for the aborted frame.
- States: IDLE, START, DATA, PARITY, STOP. All outputs are registered.
- IDLE:
  - TX_OUT=1, BUSY=0.
  - Accept condition: DATA_VALID=1 at a rising edge.
  - On accept, latch P_DATA, PAR_EN, PAR_TYP and PRESCALE (0 -> 1).
  - Parity bit latched at accept: even = XOR of P_DATA; odd = XNOR of P_DATA.
  - Go to START. Next cycle: BUSY=1, TX_OUT=0.
- Bit period:
  - Each of START, DATA bit, PARITY and STOP holds TX_OUT for exactly PS (latched prescale) cycles.
  - The clock counter runs 0..PS-1. The state/bit advances on the cycle where the counter reaches PS-1.
- DATA: sends bit index 0..DATA_W-1, LSB first. After the last bit, go to PARITY if PAR_EN latched = 1, else go to STOP.
- PARITY: TX_OUT = latched parity bit.
- STOP: TX_OUT=1. After PS cycles go to IDLE. In that first IDLE cycle BUSY=0 and DONE=1, for one cycle only.
- Frame length, accept edge to BUSY fall: PS*(DATA_W+2) cycles without parity, PS*(DATA_W+3) with parity.
- Back-to-back: DATA_VALID in the DONE cycle (BUSY=0) is accepted. The line then sits high for exactly that one IDLE cycle before the next start bit.
- Ignored during a frame: DATA_VALID, P_DATA, PAR_EN, PAR_TYP and PRESCALE are ignored while BUSY=1. Input changes never alter a frame in flight.
- Illegal state encoding: recover to IDLE with TX_OUT=1.

Test Plan:
- Even parity: P_DATA=0xA5, PAR_EN=1, PAR_TYP=0, PRESCALE=4, one DATA_VALID pulse -> TX_OUT sequence 0,1,0,1,0,0,1,0,1,0(parity),1, each held 4 cycles. BUSY high 44 cycles. DONE single pulse as BUSY falls.
- Parity type and no parity: P_DATA=0x01, PRESCALE=1. PAR_TYP=1 -> parity bit 0; PAR_TYP=0 -> parity bit 1. With PAR_EN=0 and P_DATA=0xFF -> 10-bit frame, BUSY high 10 cycles, no parity slot.
- Zero prescale: PRESCALE=0, P_DATA=0x3C, PAR_EN=0 -> behaves as PRESCALE=1, with exactly one cycle per bit.
- Ignored inputs: DATA_VALID pulsed mid-frame with P_DATA=0xFF, and PRESCALE changed mid-frame -> the current frame is unchanged (0x5A, PRESCALE=2), and no second frame starts.
- Back-to-back: DATA_VALID held high with 0x55 then 0xAA -> the second start bit begins exactly 1 cycle after the first frame's DONE. Two DONE pulses, with line high for one cycle between frames.
- Reset mid-frame: RST asserted during DATA bit 3 -> TX_OUT=1 and BUSY=0 immediately, DONE=0. After RST release, a fresh 0x81 frame transmits correctly.
